// File: rtl/sector_serializer.sv
// Serializes one cached sector as: zero preamble, a sync '1', the sector bytes MSB first,
// then the 16-bit byte-sum checksum MSB first, one bit per accepted bit_tick.
module sector_serializer #(
    parameter int PREAMBLE_BITS = 32,
    parameter int SECTOR_BYTES  = 512
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        bit_tick,
    output logic [8:0]  cache_addr,
    input  logic [7:0]  cache_rd_data,
    output logic        bit_out,
    output logic        bit_valid,
    output logic        busy,
    output logic        done,
    output logic [15:0] checksum,
    output logic [2:0]  o_dbg_state
);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_PREAMBLE = 3'd1,
        S_SYNC     = 3'd2,
        S_DATA     = 3'd3,
        S_CKSUM    = 3'd4
    } state_t;

    localparam int DATA_BITS = 8 * SECTOR_BYTES;
    localparam int CW        = $clog2(DATA_BITS > 256 ? DATA_BITS : 256);
    localparam logic [CW-1:0] PRE_LAST  = CW'(PREAMBLE_BITS - 1);
    localparam logic [CW-1:0] DATA_LAST = CW'(DATA_BITS - 1);
    localparam logic [CW-1:0] CK_LAST   = CW'(15);
    localparam logic [8:0]    ADDR_LAST = 9'(SECTOR_BYTES - 1);

    state_t        r_state;
    state_t        w_next;
    logic [CW-1:0] r_cnt;
    logic [8:0]    r_addr;
    logic [7:0]    r_hold;
    logic [7:0]    r_shift;
    logic          r_req;
    logic          r_vld;
    logic [15:0]   r_cksum;
    logic          r_bit_out;
    logic          r_bit_valid;
    logic          r_busy;
    logic          r_done;

    logic          w_start;
    logic          w_emit;
    logic          w_bit;
    logic          w_load;
    logic          w_last;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:     if (start) w_next = S_PREAMBLE;
            S_PREAMBLE: if (bit_tick && r_cnt == PRE_LAST) w_next = S_SYNC;
            S_SYNC:     if (bit_tick) w_next = S_DATA;
            S_DATA:     if (bit_tick && r_cnt == DATA_LAST) w_next = S_CKSUM;
            S_CKSUM:    if (bit_tick && r_cnt == CK_LAST) w_next = S_IDLE;
            default:    w_next = S_IDLE;
        endcase
    end

    // The first bit of each byte comes straight from the holding register as it moves into the shifter.
    always_comb begin
        w_start = 1'b0;
        w_emit  = 1'b0;
        w_bit   = 1'b0;
        w_load  = 1'b0;
        w_last  = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_start = start;
            end
            S_PREAMBLE: begin
                w_emit = bit_tick;
            end
            S_SYNC: begin
                w_emit = bit_tick;
                w_bit  = 1'b1;
            end
            S_DATA: begin
                w_emit = bit_tick;
                w_load = bit_tick && (r_cnt[2:0] == 3'd0);
                w_bit  = (r_cnt[2:0] == 3'd0) ? r_hold[7] : r_shift[7];
            end
            S_CKSUM: begin
                w_emit = bit_tick;
                w_bit  = r_cksum[~r_cnt[3:0]];
                w_last = bit_tick && (r_cnt == CK_LAST);
            end
            default: begin
                w_emit = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (w_start || (w_next != r_state)) begin
            r_cnt <= '0;
        end else if (w_emit) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    // Cache read has one cycle of latency: r_req marks a fresh address, r_vld marks data on the bus.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_addr <= '0;
            r_req  <= 1'b0;
            r_vld  <= 1'b0;
            r_hold <= '0;
        end else begin
            r_req <= w_start || w_load;
            r_vld <= r_req;
            if (w_start) begin
                r_addr <= '0;
            end else if (w_load && (r_addr != ADDR_LAST)) begin
                r_addr <= r_addr + 1'b1;
            end
            if (r_vld) begin
                r_hold <= cache_rd_data;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_shift <= '0;
            r_cksum <= '0;
        end else if (w_start) begin
            r_shift <= '0;
            r_cksum <= '0;
        end else if (w_load) begin
            r_shift <= {r_hold[6:0], 1'b0};
            r_cksum <= r_cksum + {8'd0, r_hold};
        end else if (w_emit && (r_state == S_DATA)) begin
            r_shift <= {r_shift[6:0], 1'b0};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_bit_out   <= 1'b0;
            r_bit_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_bit_valid <= w_emit;
            r_busy      <= (w_next != S_IDLE);
            r_done      <= w_last;
            if (w_emit) begin
                r_bit_out <= w_bit;
            end
        end
    end

    assign cache_addr  = r_addr;
    assign bit_out     = r_bit_out;
    assign bit_valid   = r_bit_valid;
    assign busy        = r_busy;
    assign done        = r_done;
    assign checksum    = r_cksum;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_sector_serializer.sv
// Bench for sector_serializer: a sector-level model builds the expected bit stream
// into a queue; a negedge monitor pops and compares every bit_valid strobe.
module tb_sector_serializer;

    localparam int PRE = 32;
    localparam int SB  = 512;
    localparam int W   = 2;

    logic        clk;
    logic        rst;
    logic        start;
    logic        bit_tick;
    logic [8:0]  cache_addr;
    logic [7:0]  cache_rd_data;
    logic        bit_out;
    logic        bit_valid;
    logic        busy;
    logic        done;
    logic [15:0] checksum;
    logic [2:0]  o_dbg_state;

    logic [7:0]   mem [SB];
    logic [W-1:0] exp_q[$];
    logic [15:0]  exp_ck_q[$];

    int checks   = 0;
    int failures = 0;
    int n_bits   = 0;
    int tick_min = 4;
    int tick_max = 4;
    bit tick_en  = 1'b0;

    sector_serializer #(
        .PREAMBLE_BITS(PRE),
        .SECTOR_BYTES (SB)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .bit_tick     (bit_tick),
        .cache_addr   (cache_addr),
        .cache_rd_data(cache_rd_data),
        .bit_out      (bit_out),
        .bit_valid    (bit_valid),
        .busy         (busy),
        .done         (done),
        .checksum     (checksum),
        .o_dbg_state  (o_dbg_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // sector cache with a one-cycle registered read
    always @(posedge clk) cache_rd_data <= mem[cache_addr];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: preamble zeros, sync one, bytes MSB first, byte sum mod 2^16 MSB first.
    function automatic void push_sector();
        int          sum;
        logic [15:0] ck;
        sum = 0;
        for (int i = 0; i < PRE; i++) exp_q.push_back(2'b00);
        exp_q.push_back(2'b01);
        for (int i = 0; i < SB; i++) begin
            for (int b = 7; b >= 0; b--) exp_q.push_back({1'b0, mem[i][b]});
            sum = sum + int'(mem[i]);
        end
        ck = sum[15:0];
        for (int b = 15; b >= 0; b--) exp_q.push_back({(b == 0), ck[b]});
        exp_ck_q.push_back(ck);
    endfunction

    // bit_tick generator, spacing drawn from [tick_min, tick_max]
    initial begin
        int cd;
        cd = 0;
        bit_tick = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (tick_en && cd == 0) begin
                bit_tick = 1'b1;
                cd = int'($urandom_range(tick_max, tick_min)) - 1;
            end else begin
                bit_tick = 1'b0;
                if (cd > 0) cd--;
            end
        end
    end

    // monitor / scoreboard
    always @(negedge clk) begin
        logic [W-1:0] e;
        if (!rst) begin
            if (bit_valid) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_bit_valid", 32'(bit_valid), 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("bit_out", 32'(bit_out), 32'(e[0]));
                    chk("done_on_last_bit", 32'(done), 32'(e[1]));
                    n_bits++;
                    if (e[1] && exp_ck_q.size() != 0) begin
                        chk("final_checksum", 32'(checksum), 32'(exp_ck_q.pop_front()));
                    end
                end
            end else if (done) begin
                chk("done_without_bit", 32'(done), 32'd0);
            end
        end
    end

    task automatic flush();
        exp_q.delete();
        exp_ck_q.delete();
    endtask

    task automatic start_sector();
        push_sector();
        n_bits = 0;
        @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        chk("busy_after_start", 32'(busy), 32'd1);
        chk("addr_after_start", 32'(cache_addr), 32'd0);
        chk("cksum_cleared_on_start", 32'(checksum), 32'd0);
    endtask

    task automatic wait_bits(input int n);
        int k;
        k = 0;
        while (n_bits < n && k < 40000) begin
            @(negedge clk);
            k++;
        end
        chk("bits_reached", 32'(n_bits >= n), 32'd1);
    endtask

    task automatic wait_done(output logic prev_busy);
        int k;
        k = 0;
        prev_busy = busy;
        while (!done && k < 30000) begin
            prev_busy = busy;
            @(posedge clk);
            #1;
            k++;
        end
        chk("done_seen", 32'(done), 32'd1);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_bit_out"}, 32'(bit_out), 32'd0);
        chk({tag, "_bit_valid"}, 32'(bit_valid), 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_done"}, 32'(done), 32'd0);
        chk({tag, "_checksum"}, 32'(checksum), 32'd0);
        chk({tag, "_addr"}, 32'(cache_addr), 32'd0);
        chk({tag, "_state"}, 32'(o_dbg_state), 32'd0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic pb;
        rst   = 1'b1;
        start = 1'b0;
        for (int i = 0; i < SB; i++) mem[i] = 8'(i);
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_all_zero("reset");
        @(posedge clk);
        #1 rst = 1'b0;
        tick_en = 1'b1;

        // incrementing bytes, second start mid-stream must be ignored
        start_sector();
        wait_bits(100);
        @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        chk("busy_ignores_restart", 32'(busy), 32'd1);
        wait_done(pb);
        chk("cksum_incr", 32'(checksum), 32'h0000FF00);
        chk("addr_saturated_incr", 32'(cache_addr), 32'd511);
        chk("busy_low_at_done", 32'(busy), 32'd0);
        @(posedge clk);
        #1;
        chk("bit_count_incr", 32'(n_bits), 32'd4145);
        chk("cksum_held", 32'(checksum), 32'h0000FF00);

        // abort with async reset at bit 2000, then restart from the preamble
        start_sector();
        wait_bits(2000);
        #2 rst = 1'b1;
        #1;
        chk_all_zero("abort");
        flush();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        start_sector();
        wait_bits(PRE + 1 + 8);
        @(negedge clk);
        #2 rst = 1'b1;
        flush();
        @(posedge clk);
        #1 rst = 1'b0;

        // all 0xFF sector, then a random sector started on the done cycle
        for (int i = 0; i < SB; i++) mem[i] = 8'hFF;
        start_sector();
        wait_done(pb);
        chk("busy_before_done", 32'(pb), 32'd1);
        chk("busy_low_at_done_ff", 32'(busy), 32'd0);
        chk("cksum_ff", 32'(checksum), 32'h0000FE00);
        chk("addr_saturated_ff", 32'(cache_addr), 32'd511);
        for (int i = 0; i < SB; i++) mem[i] = 8'($urandom_range(255, 0));
        push_sector();
        tick_max = 6;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        chk("b2b_busy_high", 32'(busy), 32'd1);
        chk("b2b_cksum_zero", 32'(checksum), 32'd0);
        chk("b2b_addr_zero", 32'(cache_addr), 32'd0);
        wait_done(pb);
        chk("busy_low_at_done_rand", 32'(busy), 32'd0);

        // idle ticks must produce nothing
        repeat (40) @(posedge clk);
        #1;
        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        chk("idle_state", 32'(o_dbg_state), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sector_serializer.md
SECTOR_SERIALIZER -- requirements
Module: sector_serializer

Interface
REQ-001 Parameter PREAMBLE_BITS, default 32: number of zero bits sent before the sync bit (range 1..255).
REQ-002 Parameter SECTOR_BYTES, default 512: sector length in bytes; equals the sector cache depth.
REQ-003 The module SHALL have exactly one clock and an asynchronous, active-high reset; all state SHALL reset on assertion without waiting for a clock edge.
REQ-004 Ports: clk  in  1  system clock, all logic rising-edge.
REQ-005 rst  in  1  asynchronous active-high reset.
REQ-006 start  in  1  one-cycle request to serialize the cached sector.
REQ-007 bit_tick  in  1  one-cycle bit-rate strobe; consecutive ticks are at least 4 clk cycles apart.
REQ-008 cache_addr  out  9  read address to the sector cache read port.
REQ-009 cache_rd_data  in  8  cache read data, valid 1 cycle after cache_addr.
REQ-010 bit_out  out  1  serial bit, qualified by bit_valid.
REQ-011 bit_valid  out  1  one-cycle strobe, bit_out is valid.
REQ-012 busy  out  1  high from the cycle after accepted start until done.
REQ-013 done  out  1  one-cycle pulse after the last checksum bit.
REQ-014 checksum  out  16  running/final byte sum of the sector.

Function
REQ-015 FSM states SHALL be IDLE, PREAMBLE, SYNC, DATA, CKSUM; transitions advance only on bit_tick, except for IDLE->PREAMBLE.
REQ-016 IDLE: start=1 -> PREAMBLE; set cache_addr=0, clear checksum and bit counters; bit_tick in the same cycle as start SHALL be ignored.
REQ-017 start while busy=1 SHALL be ignored.
REQ-018 PREAMBLE: each bit_tick emits bit 0; after PREAMBLE_BITS ticks -> SYNC.
REQ-019 SYNC: the next bit_tick emits bit 1 -> DATA.
REQ-020 DATA: bytes sent in address order 0..SECTOR_BYTES-1, each MSB first; after 8*SECTOR_BYTES ticks -> CKSUM.
REQ-021 Prefetch: byte 0 SHALL be latched into a holding register 1 cycle after entering PREAMBLE; whenever a byte moves from the holding register into the shift register, cache_addr SHALL increment and the holding register SHALL refill 1 cycle later.
REQ-022 cache_addr SHALL saturate at SECTOR_BYTES-1 and SHALL NOT wrap during a sector.
REQ-023 checksum SHALL add each byte, zero-extended, modulo 2^16 when the byte is loaded into the shift register; carries out of bit 15 are discarded.
REQ-024 CKSUM: the final 16-bit checksum is emitted MSB first on 16 ticks; after the 16th tick -> IDLE with done=1 for one cycle.
REQ-025 bit_valid SHALL pulse exactly 1 cycle after each bit_tick accepted in PREAMBLE/SYNC/DATA/CKSUM; bit_out is registered and holds its value until the next bit.
REQ-026 bit_tick in IDLE SHALL produce no bit_valid.
REQ-027 busy SHALL fall in the same cycle done pulses; checksum SHALL hold its final value until the next accepted start.
REQ-028 start in the same cycle as done is accepted; this allows back-to-back sectors.

Reset
REQ-029 On rst: state=IDLE, cache_addr=0, bit_out=0, bit_valid=0, busy=0, done=0, checksum=0, holding and shift registers=0.
REQ-030 rst mid-sector SHALL abort without a done pulse; the next start SHALL restart from preamble bit 0 and address 0.

Verification
REQ-031 Cache byte i = i[7:0], default parameters, tick every 4 cycles, start -> 32 zeros, one 1, 4096 data bits (00,01,..,FF twice), then 0xFF00 MSB first; done after the 4145th bit_valid; checksum=0xFF00.
REQ-032 All bytes 0xFF -> checksum = 512*255 mod 65536 = 0xFE00; last 16 bits are 1111111000000000.
REQ-033 start pulsed again at bit 100 -> ignored; stream identical to REQ-031.
REQ-034 rst asserted at bit 2000 -> all outputs 0 immediately; new start -> first 33 bits are 32 zeros then one 1, first data byte 0x00.
REQ-035 Ticks at the minimum 4-cycle spacing across byte boundaries -> no bit dropped or duplicated; cache_addr stops at 511.
REQ-036 start coincident with done -> second stream begins; busy stays low for exactly one cycle, and the checksum reset to 0 is visible.
